// File: rtl/prio_pkg.sv
// Shared types for the priority decoder: code/one-hot types, FSM states,
// and the code-to-one-hot decode used by the datapath.
package prio_pkg;

  typedef logic [1:0] code_t;
  typedef logic [3:0] onehot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam onehot_t OH_C0 = 4'b1000;
  localparam onehot_t OH_C1 = 4'b0100;
  localparam onehot_t OH_C2 = 4'b0010;
  localparam onehot_t OH_C3 = 4'b0001;

  // Code 0 is the highest priority and maps to the MSB, so a
  // highest-bit-first priority encoder returns the original code.
  function automatic onehot_t decode(code_t c);
    onehot_t oh;
    oh = '0;
    unique case (1'b1)
      (c == 2'd0): oh = OH_C0;
      (c == 2'd1): oh = OH_C1;
      (c == 2'd2): oh = OH_C2;
      (c == 2'd3): oh = OH_C3;
      default:     oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/prio_dec_cnt.sv
// 4-bit load/decrement counter that saturates at zero.
// Ports: clk, rst, load, load_val[3:0], dec, zero.
module prio_dec_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/priority_dec.sv
// Decodes an accepted 2-bit code into a one-hot word held for HOLD cycles,
// followed by GAP idle cycles. Ports: clk, rst, code, in_valid, in_ready,
// onehot, out_valid, busy; with PRIO_DEC_PARITY_EN also in_par, par_err.
module priority_dec #(
  parameter int HOLD = 2,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] onehot,
  output logic       out_valid,
`ifdef PRIO_DEC_PARITY_EN
  input  logic       in_par,
  output logic       par_err,
`endif
  output logic       busy
);
  import prio_pkg::*;

  localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);
  localparam logic [3:0] GAP_LD  = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam logic       HAS_GAP = (GAP > 0);

  state_t  state;
  state_t  state_nx;
  onehot_t oh_q;
  logic    accept;
  logic    bad;
  logic    take;
  logic    zero;
  logic    cnt_ld;
  logic    [3:0] cnt_val;
  logic    cnt_dec;

  assign accept = in_valid && in_ready;

`ifdef PRIO_DEC_PARITY_EN
  assign bad = (in_par != ^code);
`else
  assign bad = 1'b0;
`endif

  // A parity-failed accept is consumed but never starts a window.
  assign take = accept && !bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (zero) begin
          state_nx = HAS_GAP ? prio_pkg::GAP : IDLE;
        end
      end
      prio_pkg::GAP: begin
        if (zero) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DRIVE);
    busy      = (state != IDLE);
    onehot    = out_valid ? oh_q : 4'b0000;
  end

  always_comb begin
    cnt_ld  = 1'b0;
    cnt_val = 4'd0;
    if (take) begin
      cnt_ld  = 1'b1;
      cnt_val = HOLD_LD;
    end else if ((state == DRIVE) && zero && HAS_GAP) begin
      cnt_ld  = 1'b1;
      cnt_val = GAP_LD;
    end
    cnt_dec = !cnt_ld && (state != IDLE);
  end

  prio_dec_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_ld),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oh_q <= 4'b0000;
    end else if (take) begin
      oh_q <= decode(code);
    end
  end

`ifdef PRIO_DEC_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= accept && bad;
    end
  end
`endif

endmodule

// File: tb/tb_priority_dec.sv
// Bench for priority_dec: timestamp model compared every cycle on two
// instances (HOLD=2/GAP=1 and HOLD=1/GAP=0) plus directed literal checks.
module tb_priority_dec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] code    [2];
  logic       vld     [2];
  logic       bad_par [2];
  logic       par     [2];
  logic       rdy     [2];
  logic [3:0] oh      [2];
  logic       ov      [2];
  logic       bsy     [2];
  logic       perr    [2];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : g_par
    assign par[g] = (^code[g]) ^ bad_par[g];
  end

  priority_dec #(.HOLD(2), .GAP(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .code      (code[0]),
    .in_valid  (vld[0]),
    .in_ready  (rdy[0]),
    .onehot    (oh[0]),
    .out_valid (ov[0]),
`ifdef PRIO_DEC_PARITY_EN
    .in_par    (par[0]),
    .par_err   (perr[0]),
`endif
    .busy      (bsy[0])
  );

  priority_dec #(.HOLD(1), .GAP(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .code      (code[1]),
    .in_valid  (vld[1]),
    .in_ready  (rdy[1]),
    .onehot    (oh[1]),
    .out_valid (ov[1]),
`ifdef PRIO_DEC_PARITY_EN
    .in_par    (par[1]),
    .par_err   (perr[1]),
`endif
    .busy      (bsy[1])
  );

`ifndef PRIO_DEC_PARITY_EN
  assign perr[0] = 1'b0;
  assign perr[1] = 1'b0;
`endif

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest set bit wins; MSB is code 0.
  function automatic int prio_enc(logic [3:0] v);
    for (int b = 3; b >= 0; b--) begin
      if (v[b]) return 3 - b;
    end
    return -1;
  endfunction

  // Model: a cycle index plus timestamps of the drive window and of the
  // first cycle the block is ready again.
  int cyc = 0;
  int hold_p [2] = '{2, 1};
  int gap_p  [2] = '{1, 0};
  int ready_at [2];
  int win_lo   [2];
  int win_hi   [2];
  int perr_at  [2];
  logic [3:0] exp_oh [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ready_at[i] = 0;
        win_lo[i]   = 0;
        win_hi[i]   = -1;
        perr_at[i]  = -1;
        exp_oh[i]   = 4'b0000;
      end else if (vld[i] && cyc >= ready_at[i]) begin
`ifdef PRIO_DEC_PARITY_EN
        if (par[i] != ^code[i]) begin
          perr_at[i] = cyc + 1;
        end else
`endif
        begin
          win_lo[i]   = cyc + 1;
          win_hi[i]   = cyc + hold_p[i];
          ready_at[i] = cyc + hold_p[i] + gap_p[i] + 1;
          exp_oh[i]   = 4'b1000 >> code[i];
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic e_ov, e_busy, e_rdy, e_perr;
      logic [3:0] e_oh;
      e_ov   = !rst && cyc >= win_lo[i] && cyc <= win_hi[i];
      e_busy = !rst && cyc < ready_at[i];
      e_rdy  = !rst && !e_busy;
      e_perr = !rst && cyc == perr_at[i];
      e_oh   = e_ov ? exp_oh[i] : 4'b0000;
      chk($sformatf("model_ov%0d", i), int'(ov[i]), int'(e_ov));
      chk($sformatf("model_oh%0d", i), int'(oh[i]), int'(e_oh));
      chk($sformatf("model_busy%0d", i), int'(bsy[i]), int'(e_busy));
      chk($sformatf("model_rdy%0d", i), int'(rdy[i]), int'(e_rdy));
      chk($sformatf("model_perr%0d", i), int'(perr[i]), int'(e_perr));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] tbl [4];
    tbl = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < 2; i++) begin
      code[i] = 2'd0;
      vld[i] = 1'b0;
      bad_par[i] = 1'b0;
    end
    rst = 1'b1;
    step();
    chk("rst_ready", int'(rdy[0]), 0);
    chk("rst_ov", int'(ov[0]), 0);
    chk("rst_oh", int'(oh[0]), 0);
    chk("rst_busy", int'(bsy[0]), 0);
    step();
    rst = 1'b0;
    #1;
    chk("rel_ready", int'(rdy[0]), 1);

    // Single request, code 2.
    code[0] = 2'd2;
    vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    chk("c2_oh1", int'(oh[0]), 4'b0010);
    chk("c2_ov1", int'(ov[0]), 1);
    step();
    chk("c2_oh2", int'(oh[0]), 4'b0010);
    chk("c2_ov2", int'(ov[0]), 1);
    step();
    chk("c2_gap_ov", int'(ov[0]), 0);
    chk("c2_gap_busy", int'(bsy[0]), 1);
    chk("c2_gap_rdy", int'(rdy[0]), 0);
    step();
    chk("c2_idle_rdy", int'(rdy[0]), 1);

    // All four codes and their re-encoding.
    for (int c = 0; c < 4; c++) begin
      code[0] = 2'(c);
      vld[0] = 1'b1;
      step();
      vld[0] = 1'b0;
      chk($sformatf("seq_oh%0d", c), int'(oh[0]), int'(tbl[c]));
      chk($sformatf("seq_enc%0d", c), prio_enc(oh[0]), c);
      repeat (3) step();
    end

    // Code changes during the window are ignored.
    code[0] = 2'd3;
    vld[0] = 1'b1;
    step();
    code[0] = 2'd1;
    chk("hold_oh1", int'(oh[0]), 4'b0001);
    step();
    chk("hold_oh2", int'(oh[0]), 4'b0001);
    step();
    chk("hold_gap_ov", int'(ov[0]), 0);
    step();
    chk("hold_rdy", int'(rdy[0]), 1);
    step();
    vld[0] = 1'b0;
    chk("hold_next_oh", int'(oh[0]), 4'b0100);
    repeat (3) step();

    // Reset in the second drive cycle, between edges.
    code[0] = 2'd0;
    vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    step();
    chk("mid_ov_pre", int'(ov[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_oh", int'(oh[0]), 0);
    chk("mid_ov", int'(ov[0]), 0);
    chk("mid_rdy", int'(rdy[0]), 0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rel_rdy", int'(rdy[0]), 1);
    chk("mid_rel_busy", int'(bsy[0]), 0);
    step();
    chk("mid_no_resume", int'(ov[0]), 0);

    // Accept on the first edge after reset release.
    rst = 1'b1;
    code[0] = 2'd1;
    vld[0] = 1'b1;
    step();
    rst = 1'b0;
    step();
    vld[0] = 1'b0;
    chk("first_edge_oh", int'(oh[0]), 4'b0100);
    chk("first_edge_ov", int'(ov[0]), 1);
    repeat (3) step();

    // Back-to-back on HOLD=1, GAP=0.
    code[1] = 2'd0;
    vld[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("b2b_ov%0d", k), int'(ov[1]), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("b2b_oh%0d", k), int'(oh[1]), (k % 2 == 0) ? 4'b1000 : 4'b0000);
    end
    vld[1] = 1'b0;
    repeat (2) step();

`ifdef PRIO_DEC_PARITY_EN
    code[0] = 2'd3;
    bad_par[0] = 1'b1;
    vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    bad_par[0] = 1'b0;
    chk("par_err", int'(perr[0]), 1);
    chk("par_ov", int'(ov[0]), 0);
    chk("par_rdy", int'(rdy[0]), 1);
    step();
    chk("par_err_clr", int'(perr[0]), 0);
    chk("par_ov2", int'(ov[0]), 0);
    repeat (2) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
